cu_adc_spi_capture: RTL and testbench
=====================================

CU_ADC_SPI_CAPTURE -- requirements
Module: cu_adc_spi_capture

Interface
REQ-001 SHALL have parameter SCK_HALF, default 4: clk cycles per adc_sck half-period (legal range 1..255).
REQ-002 SHALL have parameter SAMPLE_DIV, default 1000: clk cycles between conversion starts (legal values ≥ 64).
REQ-003 SHALL have parameter CNV_PULSE, default 2: adc_cnv high width in clk cycles.
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 255: maximum clk cycles spent waiting for adc_busy low.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 enable  input  1  high = periodic sampling runs.
REQ-008 adc_busy  input  1  ADC conversion in progress (high = busy).
REQ-009 adc_sdo  input  1  ADC serial data, MSB first.
REQ-010 adc_cnv  output  1  conversion start pulse.
REQ-011 adc_csn  output  1  ADC chip select, active-low.
REQ-012 adc_sck  output  1  serial clock; idles low.
REQ-013 datain  output  16  last captured two's-complement sample; feeds the decimation stage datain.
REQ-014 drdy  output  1  one-cycle pulse: datain is valid; feeds the decimation stage drdy.
REQ-015 overrun  output  1  sticky flag: a sample tick arrived while a capture was still in progress.
REQ-016 timeout_err  output  1  sticky flag: adc_busy was not seen low within BUSY_TIMEOUT cycles.

Function
REQ-017 SHALL run a tick counter 0..SAMPLE_DIV-1 while enable=1, issuing a one-cycle tick at count SAMPLE_DIV-1 and wrapping to 0; enable=0 SHALL hold the counter at 0.
REQ-018 SHALL implement FSM states IDLE, CONVST, WAITBUSY, SHIFT, DONE.
REQ-019 IDLE: on tick, go to CONVST; otherwise stay in IDLE.
REQ-020 CONVST: adc_cnv=1 for exactly CNV_PULSE cycles, then go to WAITBUSY.
REQ-021 WAITBUSY: ignore adc_busy during the first cycle; afterwards, adc_busy=0 goes to SHIFT; when the wait counter reaches BUSY_TIMEOUT, set timeout_err and go to IDLE with no drdy.
REQ-022 SHIFT: adc_csn=0; generate 16 sck periods (SCK_HALF low, then SCK_HALF high); sample adc_sdo into the shift register in the clk cycle where adc_sck goes 0->1, MSB first; after the 16th high phase, adc_sck returns low and the FSM goes to DONE.
REQ-023 DONE: adc_csn=1; datain <= shift register; drdy=1 for exactly one cycle; go to IDLE.
REQ-024 adc_csn SHALL be 1 in every state except SHIFT; adc_sck SHALL be 0 outside SHIFT.
REQ-025 Latency: with SCK_HALF=4, CNV_PULSE=2 and busy dropping in the first checked WAITBUSY cycle, drdy SHALL assert 2+2+128+1 cycles after the tick (±1 cycle documented in the test plan).
REQ-026 A tick outside IDLE SHALL set overrun and be dropped; the capture in progress continues undisturbed.
REQ-027 Deasserting enable mid-capture SHALL NOT abort it; the capture completes with drdy, and no further ticks occur.
REQ-028 datain SHALL hold its value between drdy pulses.
REQ-029 Bit counter 5 bits and wait counter 8 bits, no wrap-around inside a capture; the sck divider counter is sized from SCK_HALF.

Reset
REQ-030 On rst=1 at a clock edge: FSM=IDLE, all counters=0, adc_cnv=0, adc_csn=1, adc_sck=0, datain=0, drdy=0, overrun=0, timeout_err=0.
REQ-031 Reset mid-SHIFT SHALL drop the partial word and produce no drdy; adc_csn SHALL be 1 on the cycle after the reset edge.
REQ-032 overrun and timeout_err SHALL clear only on rst.

Structure
REQ-033 FSM state encoding and default parameter values SHALL live in the shared logger package.
REQ-034 The sck divider plus 16-bit shift register SHALL be one sub-module, cu_spi_rx16; the FSM and tick counter stay in the top.

Verification
REQ-035 Nominal run: SAMPLE_DIV=64, ADC model returns 16'h8001 -> drdy pulses every 64 cycles and datain=16'h8001 at each pulse.
REQ-036 Bit order: model returns 16'hA5C3 -> datain=16'hA5C3, exactly 16 sck rising edges per capture, csn low only during SHIFT.
REQ-037 Timeout: adc_busy held high -> timeout_err=1 after 255 WAITBUSY cycles, no drdy, next tick starts a fresh capture.
REQ-038 Overrun: SCK_HALF=8, SAMPLE_DIV=64 -> overrun=1, every capture completes, drdy once per completed capture.
REQ-039 Reset during SHIFT bit 7 -> next cycle csn=1, sck=0, datain=0, no drdy.
REQ-040 enable dropped during CONVST -> one drdy follows, then none for 3×SAMPLE_DIV cycles.

Source files
------------

// File: rtl/cu_adc_spi_capture_pkg.sv
// Shared definitions for the ADC SPI capture block: FSM encoding, counter widths,
// parameter defaults and a counter-width helper.
package cu_adc_spi_capture_pkg;

  localparam int DEF_SCK_HALF     = 4;
  localparam int DEF_SAMPLE_DIV   = 1000;
  localparam int DEF_CNV_PULSE    = 2;
  localparam int DEF_BUSY_TIMEOUT = 255;

  localparam int STATE_W    = 3;
  localparam int BIT_CNT_W  = 5;
  localparam int WAIT_CNT_W = 8;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_CONVST   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAITBUSY = 3'd2;
  localparam logic [STATE_W-1:0] ST_SHIFT    = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cu_spi_rx16.sv
// SPI receive engine: produces 16 adc_sck periods (low half first) and shifts
// adc_sdo in MSB first on each rising sck edge.
module cu_spi_rx16
  import cu_adc_spi_capture_pkg::*;
#(
  parameter int SCK_HALF = DEF_SCK_HALF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sdo,
  output logic        sck,
  output logic        done,
  output logic [15:0] data
);

  localparam int                 DIV_W    = cnt_width(SCK_HALF);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCK_HALF - 1);

  logic                 active_q, active_d;
  logic                 sck_q, sck_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [15:0]          shreg_q, shreg_d;
  logic                 half_end;

  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    half_end = active_q && (div_q == DIV_LAST);
    done     = half_end && sck_q && (bit_q == BIT_CNT_W'(15));

    if (start) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      shreg_d  = '0;
    end else if (active_q) begin
      if (half_end) begin
        div_d = '0;
        if (!sck_q) begin
          // sdo is captured on the same clk edge that raises sck
          sck_d   = 1'b1;
          shreg_d = {shreg_q[14:0], sdo};
        end else begin
          sck_d = 1'b0;
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_CNT_W'(15)) begin
            active_d = 1'b0;
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

  assign sck  = sck_q;
  assign data = shreg_q;

endmodule

// File: rtl/cu_adc_spi_capture.sv
// Periodic ADC capture: a sample tick starts a conversion, waits for busy to
// drop, reads 16 bits over SPI and presents the word with a one-cycle drdy.
module cu_adc_spi_capture
  import cu_adc_spi_capture_pkg::*;
#(
  parameter int SCK_HALF     = DEF_SCK_HALF,
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int CNV_PULSE    = DEF_CNV_PULSE,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_busy,
  input  logic        adc_sdo,
  output logic        adc_cnv,
  output logic        adc_csn,
  output logic        adc_sck,
  output logic [15:0] datain,
  output logic        drdy,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int                    TICK_W    = cnt_width(SAMPLE_DIV);
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam int                    CNV_W     = cnt_width(CNV_PULSE);
  localparam logic [CNV_W-1:0]      CNV_LAST  = CNV_W'(CNV_PULSE - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(BUSY_TIMEOUT - 1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [CNV_W-1:0]      cnv_cnt_q, cnv_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]           datain_q, datain_d;
  logic                  drdy_q, drdy_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;
  logic                  tick;
  logic                  spi_start, spi_done, spi_sck;
  logic [15:0]           spi_data;

  always_comb begin
    tick = enable && (tick_cnt_q == TICK_LAST);
    if (!enable || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnv_cnt_d  = cnv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    datain_d   = datain_q;
    drdy_d     = 1'b0;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    spi_start  = 1'b0;

    // A tick is only consumed in IDLE; anywhere else it is dropped and flagged.
    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d   = ST_CONVST;
          cnv_cnt_d = '0;
        end
      end
      ST_CONVST: begin
        if (cnv_cnt_q == CNV_LAST) begin
          state_d    = ST_WAITBUSY;
          cnv_cnt_d  = '0;
          wait_cnt_d = '0;
        end else begin
          cnv_cnt_d = cnv_cnt_q + 1'b1;
        end
      end
      ST_WAITBUSY: begin
        // busy is not trusted in the first cycle right after the cnv pulse
        wait_cnt_d = wait_cnt_q + 1'b1;
        if ((wait_cnt_q != '0) && !adc_busy) begin
          state_d    = ST_SHIFT;
          spi_start  = 1'b1;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_IDLE;
          timeout_d  = 1'b1;
          wait_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (spi_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        datain_d = spi_data;
        drdy_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      cnv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      datain_q   <= '0;
      drdy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      cnv_cnt_q  <= cnv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      datain_q   <= datain_d;
      drdy_q     <= drdy_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  cu_spi_rx16 #(
    .SCK_HALF (SCK_HALF)
  ) u_spi_rx16 (
    .clk   (clk),
    .rst   (rst),
    .start (spi_start),
    .sdo   (adc_sdo),
    .sck   (spi_sck),
    .done  (spi_done),
    .data  (spi_data)
  );

  assign adc_cnv     = (state_q == ST_CONVST);
  assign adc_csn     = (state_q != ST_SHIFT);
  assign adc_sck     = spi_sck && (state_q == ST_SHIFT);
  assign datain      = datain_q;
  assign drdy        = drdy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_cu_adc_spi_capture.sv
// Bench for cu_adc_spi_capture: a behavioural ADC plus a transaction scoreboard
// on a fast-sck instance, and a slow-sck instance exercising overrun.
module tb_cu_adc_spi_capture;

  localparam int SH_A = 1;
  localparam int SH_B = 8;
  localparam int SD   = 64;
  localparam int CNV  = 2;
  localparam int BT   = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, enable = 1'b0, adc_busy = 1'b0, adc_sdo;
  logic        adc_cnv, adc_csn, adc_sck, drdy, overrun, timeout_err;
  logic [15:0] datain;

  logic        rst_b = 1'b1, enable_b = 1'b0, adc_sdo_b;
  logic        adc_cnv_b, adc_csn_b, adc_sck_b, drdy_b, overrun_b, timeout_b;
  logic [15:0] datain_b;

  cu_adc_spi_capture #(
    .SCK_HALF(SH_A), .SAMPLE_DIV(SD), .CNV_PULSE(CNV), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_busy(adc_busy), .adc_sdo(adc_sdo),
    .adc_cnv(adc_cnv), .adc_csn(adc_csn), .adc_sck(adc_sck), .datain(datain),
    .drdy(drdy), .overrun(overrun), .timeout_err(timeout_err)
  );

  cu_adc_spi_capture #(
    .SCK_HALF(SH_B), .SAMPLE_DIV(SD), .CNV_PULSE(CNV), .BUSY_TIMEOUT(BT)
  ) dut_b (
    .clk(clk), .rst(rst_b), .enable(enable_b), .adc_busy(1'b0), .adc_sdo(adc_sdo_b),
    .adc_cnv(adc_cnv_b), .adc_csn(adc_csn_b), .adc_sck(adc_sck_b), .datain(datain_b),
    .drdy(drdy_b), .overrun(overrun_b), .timeout_err(timeout_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Behavioural ADC: a new word per conversion, busy high for conv cycles.
  logic [15:0] fixed_word = 16'h8001;
  logic [15:0] adc_word   = '0;
  bit          rand_mode  = 1'b0;
  bit          force_busy = 1'b0;
  logic        cnv_seen   = 1'b0;
  int          busy_cnt   = 0;
  int          nrise      = 0;

  always @(posedge clk) begin
    if (rst) begin
      adc_busy <= 1'b0;
      cnv_seen <= 1'b0;
      busy_cnt <= 0;
    end else begin
      cnv_seen <= adc_cnv;
      if (adc_cnv && !cnv_seen) begin
        adc_word <= rand_mode ? 16'($urandom) : fixed_word;
        adc_busy <= 1'b1;
        busy_cnt <= rand_mode ? int'($urandom_range(15, 1)) : 1;
      end else if (adc_busy && !force_busy) begin
        if (busy_cnt <= 1) adc_busy <= 1'b0;
        else busy_cnt <= busy_cnt - 1;
      end
    end
  end

  assign adc_sdo = (nrise < 16) ? adc_word[15-nrise] : 1'b0;

  // Scoreboard / protocol monitor for the fast instance.
  logic [15:0] exp_q[$];
  int   last_rises = 0, low_len = 0, drdy_cnt = 0, rise_cyc = 0, fall_cyc = 0;
  logic sck_p = 1'b0, csn_p = 1'b1, cnv_p = 1'b0;
  logic [15:0] hold = '0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      nrise = 0; low_len = 0; sck_p = 1'b0; csn_p = 1'b1; cnv_p = 1'b0;
      hold = '0;
      exp_q.delete();
    end else begin
      chk("sck_high_needs_csn_low", {31'd0, adc_sck & adc_csn}, 32'd0);
      if (adc_sck && !sck_p) nrise++;
      if (!adc_csn) low_len++;
      if (adc_cnv && !cnv_p) rise_cyc = cyc;
      if (!adc_cnv && cnv_p) begin
        fall_cyc = cyc;
        if (!force_busy) exp_q.push_back(adc_word);
      end
      if (adc_csn && !csn_p) begin
        chk("csn_low_len", low_len, 32 * SH_A);
        last_rises = nrise;
        nrise = 0;
        low_len = 0;
      end
      if (drdy) begin
        drdy_cnt++;
        chk("sck_rises", last_rises, 16);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL drdy_unexpected: observed datain=%0h expected no drdy", datain);
        end else begin
          chk("datain", datain, exp_q.pop_front());
        end
        hold = datain;
      end else begin
        chk("datain_hold", datain, hold);
      end
      sck_p = adc_sck; csn_p = adc_csn; cnv_p = adc_cnv;
    end
  end

  // Slow instance ADC: fixed pattern, busy never asserted.
  logic [15:0] pat_b = 16'h3C5A;
  logic        sck_bp = 1'b0;
  int          nrise_b = 0;
  assign adc_sdo_b = (nrise_b < 16) ? pat_b[15-nrise_b] : 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst_b || adc_csn_b) nrise_b = 0;
    else if (adc_sck_b && !sck_bp) nrise_b++;
    sck_bp = adc_sck_b;
  end

  task automatic wait_drdy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drdy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_drdy_b(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drdy_b) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int t0, n0;
    int lat_nom, per_b;
    lat_nom = CNV + 2 + 32 * SH_A + 1;
    per_b   = SD * ((CNV + 2 + 32 * SH_B + 1 + SD - 1) / SD);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cnv", adc_cnv, 0);
    chk("rst_csn", adc_csn, 1);
    chk("rst_sck", adc_sck, 0);
    chk("rst_datain", datain, 0);
    chk("rst_drdy", drdy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    @(posedge clk); #1;
    rst = 1'b0; rst_b = 1'b0;
    $display("step reset released at cycle %0d", cyc);

    // Nominal: fixed 16'h8001, one drdy per sample period.
    enable = 1'b1;
    wait_drdy(200, ok);
    chk("nom_first_drdy", ok, 1);
    chk_range("nom_latency", cyc - rise_cyc, lat_nom - 1, lat_nom + 1);
    chk("nom_data", datain, 16'h8001);
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_drdy(100, ok);
      chk("nom_drdy", ok, 1);
      chk("nom_period", cyc - t0, SD);
      $display("step nominal drdy at cycle %0d datain=%h", cyc, datain);
      t0 = cyc;
    end

    // Bit order.
    @(posedge clk); #1;
    fixed_word = 16'hA5C3;
    wait_drdy(100, ok);
    chk("bits_drdy", ok, 1);
    chk("bits_data", datain, 16'hA5C3);
    chk("bits_rises", last_rises, 16);
    $display("step bit order datain=%h", datain);

    // Random words and conversion times.
    rand_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_drdy(100, ok);
      chk("rand_drdy", ok, 1);
      $display("step random capture %0d datain=%h", k, datain);
    end
    chk("rand_overrun", overrun, 0);
    chk("rand_timeout", timeout_err, 0);

    // Enable dropped during the conversion pulse.
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (adc_cnv) begin ok = 1'b1; break; end
    end
    chk("en_cnv_seen", ok, 1);
    @(posedge clk); #1;
    enable = 1'b0;
    n0 = drdy_cnt;
    wait_drdy(100, ok);
    chk("en_final_drdy", ok, 1);
    repeat (3 * SD) @(negedge clk);
    chk("en_drdy_count", drdy_cnt - n0, 1);
    $display("step enable drop: drdy after drop=%0d", drdy_cnt - n0);

    // Reset in the middle of the shift phase.
    rand_mode = 1'b0;
    fixed_word = 16'h7E81;
    @(posedge clk); #1;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!adc_csn && nrise == 7) begin ok = 1'b1; break; end
    end
    chk("rsh_bit7_seen", ok, 1);
    @(posedge clk); #1;
    rst = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    chk("rsh_csn", adc_csn, 1);
    chk("rsh_sck", adc_sck, 0);
    chk("rsh_datain", datain, 0);
    chk("rsh_drdy", drdy, 0);
    rst = 1'b0;
    n0 = drdy_cnt;
    repeat (2 * SD) @(negedge clk);
    chk("rsh_no_drdy", drdy_cnt - n0, 0);
    $display("step reset mid-shift done at cycle %0d", cyc);

    // Busy stuck high: timeout, then a fresh capture succeeds.
    force_busy = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    n0 = drdy_cnt;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (timeout_err) begin ok = 1'b1; break; end
    end
    chk("to_flag", ok, 1);
    chk_range("to_wait_len", cyc - fall_cyc, BT - 1, BT + 1);
    chk("to_no_drdy", drdy_cnt - n0, 0);
    chk("to_overrun", overrun, 1);
    @(posedge clk); #1;
    force_busy = 1'b0;
    fixed_word = 16'h5A5A;
    wait_drdy(200, ok);
    chk("to_recover_drdy", ok, 1);
    chk("to_recover_data", datain, 16'h5A5A);
    chk("to_sticky", timeout_err, 1);
    $display("step timeout recovered datain=%h", datain);
    @(posedge clk); #1;
    enable = 1'b0;

    // Slow sck instance: ticks overrun, every capture still completes.
    enable_b = 1'b1;
    wait_drdy_b(600, ok);
    chk("ovr_first_drdy", ok, 1);
    chk("ovr_data", datain_b, 16'h3C5A);
    t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      wait_drdy_b(600, ok);
      chk("ovr_drdy", ok, 1);
      chk("ovr_period", cyc - t0, per_b);
      chk("ovr_data", datain_b, 16'h3C5A);
      $display("step overrun instance drdy at cycle %0d datain=%h", cyc, datain_b);
      t0 = cyc;
    end
    chk("ovr_flag", overrun_b, 1);
    chk("ovr_timeout", timeout_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
